// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared mode encodings, state type and result select for the comparators
package cmp_pkg;

  localparam logic [1:0] MODE_NE = 2'b00;
  localparam logic [1:0] MODE_EQ = 2'b01;
  localparam logic [1:0] MODE_LT = 2'b10;
  localparam logic [1:0] MODE_GT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } cmp_state_t;

  // Maps the resolved flags onto the single-bit outcome chosen by mode.
  function automatic logic select_result(input logic [1:0] mode,
                                         input logic       eq,
                                         input logic       gt,
                                         input logic       lt);
    logic r;
    r = 1'b0;
    case (mode)
      MODE_NE: r = ~eq;
      MODE_EQ: r = eq;
      MODE_LT: r = lt;
      MODE_GT: r = gt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// rtl/cmp_bit_cell.sv - next-flag logic for one MSB-first bit pair
// Ports:
//   a_bit, b_bit : current operand bits
//   eq, gt, lt   : flags resolved so far (one-hot)
//   eq_n, gt_n, lt_n : flags after this bit pair
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic eq,
  input  logic gt,
  input  logic lt,
  output logic eq_n,
  output logic gt_n,
  output logic lt_n
);

  logic decided;
  logic a_wins;
  logic b_wins;

  // Once a more significant bit has decided the order, lower bits cannot change it.
  assign decided = gt | lt;
  assign a_wins  = a_bit & ~b_bit & ~decided;
  assign b_wins  = ~a_bit & b_bit & ~decided;

  assign gt_n = gt | a_wins;
  assign lt_n = lt | b_wins;
  assign eq_n = eq & ~a_wins & ~b_wins;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial MSB-first magnitude comparator
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start, mode    : begin a comparison (IDLE/DONE only), result select latched on start
//   bit_valid, a_bit, b_bit, bit_ready : serial operand handshake
//   busy, done     : comparison in progress / result valid and held
//   result         : mode-selected outcome, registered
//   eq, gt, lt     : one-hot comparison flags
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       bit_valid,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic       bit_ready,
  output logic       busy,
  output logic       done,
  output logic       result,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  cmp_state_t       state_q;
  cmp_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       mode_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;
  logic             result_q;
  logic             eq_n;
  logic             gt_n;
  logic             lt_n;
  logic             in_shift;
  logic             accept;
  logic             last_beat;
  logic             start_ok;

  assign in_shift  = (state_q == SHIFT);
  assign accept    = in_shift & bit_valid;
  assign last_beat = (cnt_q == LAST_IDX);
  assign start_ok  = start & ((state_q == IDLE) | (state_q == DONE));

  cmp_bit_cell u_cell (
    .a_bit (a_bit),
    .b_bit (b_bit),
    .eq    (eq_q),
    .gt    (gt_q),
    .lt    (lt_q),
    .eq_n  (eq_n),
    .gt_n  (gt_n),
    .lt_n  (lt_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      // Terminal count forces DONE, so the counter never wraps.
      SHIFT:   if (accept && last_beat) state_d = DONE;
      DONE:    if (start) state_d = SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mode_q   <= MODE_NE;
      eq_q     <= 1'b1;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      result_q <= 1'b0;
    end else if (start_ok) begin
      cnt_q    <= '0;
      mode_q   <= mode;
      eq_q     <= 1'b1;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      result_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
      eq_q  <= eq_n;
      gt_q  <= gt_n;
      lt_q  <= lt_n;
      // Uses the post-beat flags so result is correct on the edge entering DONE.
      if (last_beat) begin
        result_q <= select_result(mode_q, eq_n, gt_n, lt_n);
      end
    end
  end

  assign bit_ready = in_shift;
  assign busy      = in_shift;
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - directed and exhaustive checks of serial_magnitude_comparator
module tb_serial_magnitude_comparator;

  localparam int W = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       bit_valid;
  logic       a_bit;
  logic       b_bit;
  logic       bit_ready;
  logic       busy;
  logic       done;
  logic       result;
  logic       eq;
  logic       gt;
  logic       lt;

  int  checks;
  int  errors;
  bit  inv_en;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .bit_ready (bit_ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_result(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
    case (m)
      2'b00:   return a != b;
      2'b01:   return a == b;
      2'b10:   return a < b;
      default: return a > b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (inv_en) check("onehot", 8'($countones({eq, gt, lt})), 8'd1);
  end

  // One full comparison: start cycle (with a stray bit offered), then beats gated by vpat.
  task automatic run_cmp(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] m, input logic [15:0] vpat,
                         input bit quick, input bit poke, output int cyc);
    int k;
    logic v;
    start     = 1'b1;
    mode      = m;
    bit_valid = 1'b1;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    tick();
    start = 1'b0;
    if (!quick) begin
      check({tag, "_busy0"}, {7'b0, busy}, 8'd1);
      check({tag, "_done0"}, {7'b0, done}, 8'd0);
      check({tag, "_eq0"}, {5'b0, eq, gt, lt}, 8'b100);
    end
    k   = 0;
    cyc = 0;
    while (k < W && cyc < 64) begin
      v         = (cyc < 16) ? vpat[cyc] : 1'b1;
      bit_valid = v;
      a_bit     = a[W-1-k];
      b_bit     = b[W-1-k];
      mode      = ~m;
      start     = poke && (cyc == 1);
      tick();
      start = 1'b0;
      if (v) k++;
      cyc++;
      if (!quick) check({tag, "_done_step"}, {7'b0, done}, {7'b0, (k == W)});
    end
    bit_valid = 1'b0;
    if (k < W) check({tag, "_timeout"}, 8'(k), 8'(W));
    check({tag, "_done"}, {5'b0, done, busy, bit_ready}, 8'b100);
    check({tag, "_flags"}, {5'b0, eq, gt, lt}, {5'b0, (a == b), (a > b), (a < b)});
    check({tag, "_result"}, {7'b0, result}, {7'b0, model_result(a, b, m)});
  endtask

  int cyc;

  initial begin
    checks    = 0;
    errors    = 0;
    inv_en    = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 2'b00;
    bit_valid = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    tick();
    tick();
    inv_en = 1'b1;
    check("reset_ctl", {4'b0, bit_ready, busy, done, result}, 8'd0);
    check("reset_flags", {5'b0, eq, gt, lt}, 8'b100);
    rst = 1'b0;
    tick();

    // bit_valid while IDLE without start: nothing happens
    bit_valid = 1'b1;
    a_bit     = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;
    check("idle_valid", {4'b0, bit_ready, busy, done, result}, 8'd0);

    run_cmp("gt1010", 4'b1010, 4'b0110, 2'b11, 16'hFFFF, 1'b0, 1'b0, cyc);
    check("gt1010_cyc", 8'(cyc), 8'd4);
    run_cmp("eq1001", 4'b1001, 4'b1001, 2'b01, 16'hFFFF, 1'b0, 1'b0, cyc);
    run_cmp("ne1001", 4'b1001, 4'b1001, 2'b00, 16'hFFFF, 1'b0, 1'b0, cyc);
    run_cmp("lt_gaps", 4'b0111, 4'b1000, 2'b10, 16'h0059, 1'b0, 1'b0, cyc);
    check("lt_gaps_cyc", 8'(cyc), 8'd7);
    run_cmp("b2b_poke", 4'b0001, 4'b0000, 2'b11, 16'hFFFF, 1'b0, 1'b1, cyc);
    check("b2b_poke_cyc", 8'(cyc), 8'd4);

    // bit_valid while DONE: result and flags held
    bit_valid = 1'b1;
    a_bit     = 1'b0;
    b_bit     = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;
    check("done_hold", {4'b0, done, busy, result, gt}, 8'b1011);

    // reset mid-stream discards the partial comparison
    start = 1'b1;
    mode  = 2'b11;
    tick();
    start     = 1'b0;
    bit_valid = 1'b1;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    tick();
    a_bit = 1'b1;
    b_bit = 1'b0;
    tick();
    bit_valid = 1'b0;
    check("mid_gt", {5'b0, eq, gt, lt}, 8'b010);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_mid_ctl", {4'b0, bit_ready, busy, done, result}, 8'd0);
    check("rst_mid_flags", {5'b0, eq, gt, lt}, 8'b100);
    run_cmp("eq0011", 4'b0011, 4'b0011, 2'b01, 16'hFFFF, 1'b0, 1'b0, cyc);

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int im = 0; im < 4; im++) begin
          run_cmp("exh", 4'(ia), 4'(ib), 2'(im), 16'($urandom), 1'b1, 1'b0, cyc);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Bit-serial counterpart of the team's 4-bit parallel equality/magnitude comparators.
- Receives operands A and B one bit per handshake, MSB first, over a serial operand link.
- Resolves EQ/NE/GT/LT and presents a one-bit selected result plus full flags.
- Sits at the receiving end of the serial operand link, in front of the logic/compare datapath.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new comparison; honoured only in IDLE or DONE.
- mode  in  2  result select: 00 NE, 01 EQ, 10 LT (A<B), 11 GT (A>B); sampled on accepted start.
- bit_valid  in  1  a_bit/b_bit pair valid.
- a_bit  in  1  current bit of A, MSB first.
- b_bit  in  1  current bit of B, MSB first.
- bit_ready  out  1  block accepts a bit pair this cycle.
- busy  out  1  comparison in progress.
- done  out  1  result valid; held until next accepted start or rst.
- result  out  1  selected comparison outcome.
- eq  out  1  A==B flag; valid when done.
- gt  out  1  A>B flag; valid when done.
- lt  out  1  A<B flag; valid when done.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - bit_ready, busy, done and result are 0.
  - eq=1, gt=0, lt=0.
  - Counter is 0 and the latched mode is 00.
- FSM states: IDLE, SHIFT, DONE.
- IDLE --start--> SHIFT:
  - Latch mode.
  - Clear gt/lt, set eq=1, counter=0.
  - done deasserts on the same edge.
- SHIFT:
  - bit_ready=1 and busy=1.
  - A bit pair is accepted on a cycle with bit_valid & bit_ready.
  - On each accepted pair, if gt==0 and lt==0:
    - a_bit & ~b_bit sets gt and clears eq.
    - ~a_bit & b_bit sets lt and clears eq.
    - Equal bits leave the flags unchanged.
  - Once gt or lt is set, the flags are sticky. The remaining bits are still consumed but ignored.
  - The counter increments per accepted pair. Cycles with bit_valid=0 stall with no state change.
  - On acceptance of pair number WIDTH: go to DONE.
- DONE:
  - done=1, busy=0, bit_ready=0.
  - result = (mode==00 & ~eq) | (mode==01 & eq) | (mode==10 & lt) | (mode==11 & gt).
  - result is registered and updates on the edge entering DONE.
- Latency: done rises on the clock edge that accepts the last bit; it is visible the following cycle. Total is WIDTH accepted beats plus 1 start cycle minimum.
- Invariant: exactly one of eq, gt, lt is 1 at all times after reset.
- Boundary conditions:
  - start in SHIFT is ignored. mode changes in SHIFT are ignored.
  - start in DONE begins a new comparison; this is back-to-back and legal.
  - start and bit_valid together in IDLE: only start takes effect; the bit is not accepted (bit_ready=0).
  - bit_valid in IDLE or DONE: ignored, no state change.
  - rst mid-SHIFT: returns to IDLE with reset values next cycle; the partial comparison is discarded.
  - rst has priority over start.
  - The counter never wraps: the terminal count forces the DONE transition.

Decomposition:
- Shared package cmp_pkg holds:
  - mode encodings MODE_NE=2'b00, MODE_EQ=2'b01, MODE_LT=2'b10, MODE_GT=2'b11;
  - state typedef cmp_state_t {IDLE, SHIFT, DONE}.
  - The parallel comparators reuse the same mode constants.
- One sub-module is natural: cmp_bit_cell.
  - Combinational next-flag logic: inputs (a_bit, b_bit, eq, gt, lt); outputs (eq_n, gt_n, lt_n).
  - Built only from NOT/AND/OR.
- The FSM, counter and result mux stay in the top.

Test Plan:
- rst, start mode=11, stream A=1010 B=0110 MSB first, bit_valid=1 every cycle -> after 4 beats done=1, gt=1, eq=0, lt=0, result=1; busy=0.
- start mode=01, A=B=1001 -> done=1, eq=1, result=1. Repeat with mode=00 on the same operands -> result=0.
- start mode=10, A=0111 B=1000, bit_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats accepted, lt=1, result=1, and no acceptance while bit_valid=0.
- Back-to-back: from DONE, assert start mode=11 with A=0001 B=0000 -> done drops the next cycle, then rises after 4 beats with gt=1. Raising start during SHIFT mid-stream has no effect.
- rst after 2 beats of A=1100 B=0011 -> next cycle IDLE, busy=0, done=0, eq=1, gt=0, lt=0. A fresh compare of A=0011 B=0011 then gives eq=1.
- Exhaustive: all 256 A,B pairs × 4 modes with random bit_valid gaps -> eq/gt/lt/result match the reference model; the one-hot flag invariant is checked every cycle.
